// File: rtl/bsg_chip_link_concentrator.sv
// rtl/bsg_chip_link_concentrator.sv - N-channel ready/valid link concentrator with round-robin arbitration
// Purpose: merges num_in_p link channels onto one output link. Each beat carries its source channel id.
//          Each input has a 2-entry FIFO. Arbitration is round-robin. With packet_lock_p=1 a grant is held
//          until a beat with last=1 is sent, so multi-beat packets never interleave.
// Optional build macro: BSG_LINK_CONC_STATS_EN adds beats_o, which holds one 16-bit transferred-beat counter
//          per channel.
// Ports:
//   clk_i, reset_i          clock; asynchronous active-high reset
//   en_mask_i[num_in_p]     per-channel enable (quasi-static)
//   v_i, data_i, last_i     per-channel input beat
//   ready_o[num_in_p]       per-channel input ready
//   v_o, data_o, chan_o,    output beat, with its source channel and last flag
//   last_o, ready_i         (ready_i is the downstream ready)
//   beats_o[num_in_p]       per-channel transfer counters (stats build only)
module bsg_chip_link_concentrator #(
    parameter int num_in_p      = 4,
    parameter int width_p       = 64,
    parameter bit packet_lock_p = 1'b1,
    parameter int lg_num_in_lp  = (num_in_p > 1) ? $clog2(num_in_p) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [num_in_p-1:0]           en_mask_i,
    input  logic [num_in_p-1:0]           v_i,
    input  logic [num_in_p*width_p-1:0]   data_i,
    input  logic [num_in_p-1:0]           last_i,
    output logic [num_in_p-1:0]           ready_o,
    output logic                          v_o,
    output logic [width_p-1:0]            data_o,
    output logic [lg_num_in_lp-1:0]       chan_o,
    output logic                          last_o,
    input  logic                          ready_i
`ifdef BSG_LINK_CONC_STATS_EN
    ,
    output logic [15:0]                   beats_o [num_in_p]
`endif
);

    // HOLD pins the grant while the output is stalled.
    // LOCKED pins the grant for the rest of a packet.
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, LOCKED = 2'd2} state_e;

    localparam logic [lg_num_in_lp-1:0] last_ch_lp = lg_num_in_lp'(num_in_p - 1);

    // Each FIFO entry stores {last, data}.
    logic [width_p:0]          r_mem [num_in_p][2];
    logic [num_in_p-1:0]       r_wr_ptr;
    logic [num_in_p-1:0]       r_rd_ptr;
    logic [1:0]                r_cnt [num_in_p];
    logic [lg_num_in_lp-1:0]   r_rr_ptr;
    logic [lg_num_in_lp-1:0]   r_grant_ch;
    state_e                    r_state;

    state_e                    w_state_nxt;
    logic [lg_num_in_lp-1:0]   w_grant_ch_nxt;
    logic [num_in_p-1:0]       w_full;
    logic [num_in_p-1:0]       w_elig;
    logic [num_in_p-1:0]       w_enq;
    logic [num_in_p-1:0]       w_deq;
    logic [lg_num_in_lp-1:0]   w_scan;
    logic [lg_num_in_lp-1:0]   w_rr_ch;
    logic                      w_rr_found;
    logic [lg_num_in_lp-1:0]   w_grant;
    logic                      w_valid;
    logic                      w_xfer;
    logic [width_p:0]          w_head;

    always_comb begin
        w_full = '0;
        w_elig = '0;
        w_enq  = '0;
        for (int k = 0; k < num_in_p; k++) begin
            w_full[k] = (r_cnt[k] == 2'd2);
            w_elig[k] = (r_cnt[k] != 2'd0) & en_mask_i[k];
            w_enq[k]  = v_i[k] & ~w_full[k] & ~reset_i;
        end
    end

    assign ready_o = ~w_full & {num_in_p{~reset_i}};

    // The search starts at r_rr_ptr and wraps from the last channel back to channel 0.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_ch    = '0;
        w_scan     = r_rr_ptr;
        for (int i = 0; i < num_in_p; i++) begin
            if (!w_rr_found && w_elig[w_scan]) begin
                w_rr_found = 1'b1;
                w_rr_ch    = w_scan;
            end
            w_scan = (w_scan == last_ch_lp) ? '0 : w_scan + lg_num_in_lp'(1);
        end
    end

    // A pinned grant ignores en_mask_i.
    // A stalled or locked channel keeps the output even if its enable drops.
    always_comb begin
        w_grant = w_rr_ch;
        w_valid = w_rr_found;
        if (r_state != IDLE) begin
            w_grant = r_grant_ch;
            w_valid = (r_cnt[r_grant_ch] != 2'd0);
        end
    end

    assign w_head = r_mem[w_grant][r_rd_ptr[w_grant]];
    assign w_xfer = w_valid & ready_i;

    always_comb begin
        w_deq = '0;
        for (int k = 0; k < num_in_p; k++) begin
            w_deq[k] = w_xfer & (w_grant == lg_num_in_lp'(k));
        end
    end

    assign v_o    = w_valid;
    assign data_o = w_valid ? w_head[width_p-1:0] : '0;
    assign chan_o = w_valid ? w_grant : '0;
    assign last_o = w_valid & w_head[width_p];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int k = 0; k < num_in_p; k++) begin
                r_cnt[k]    <= '0;
                r_mem[k][0] <= '0;
                r_mem[k][1] <= '0;
            end
        end else begin
            for (int k = 0; k < num_in_p; k++) begin
                if (w_enq[k]) begin
                    r_mem[k][r_wr_ptr[k]] <= {last_i[k], data_i[k*width_p +: width_p]};
                    r_wr_ptr[k]           <= ~r_wr_ptr[k];
                end
                if (w_deq[k]) begin
                    r_rd_ptr[k] <= ~r_rd_ptr[k];
                end
                case ({w_enq[k], w_deq[k]})
                    2'b10:   r_cnt[k] <= r_cnt[k] + 2'd1;
                    2'b01:   r_cnt[k] <= r_cnt[k] - 2'd1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_ch_nxt = r_grant_ch;
        if (w_xfer) begin
            w_grant_ch_nxt = w_grant;
            w_state_nxt    = (packet_lock_p && !w_head[width_p]) ? LOCKED : IDLE;
        end else if (w_valid && (r_state == IDLE)) begin
            w_state_nxt    = HOLD;
            w_grant_ch_nxt = w_grant;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= IDLE;
            r_grant_ch <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant_ch <= w_grant_ch_nxt;
            if (w_xfer) begin
                r_rr_ptr <= (w_grant == last_ch_lp) ? '0 : w_grant + lg_num_in_lp'(1);
            end
        end
    end

`ifdef BSG_LINK_CONC_STATS_EN
    logic [15:0] r_beats [num_in_p];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < num_in_p; k++) begin
                r_beats[k] <= '0;
            end
        end else begin
            for (int k = 0; k < num_in_p; k++) begin
                if (w_deq[k]) begin
                    r_beats[k] <= r_beats[k] + 16'd1;
                end
            end
        end
    end

    assign beats_o = r_beats;
`endif

endmodule

// File: tb/tb_bsg_chip_link_concentrator.sv
// tb/tb_bsg_chip_link_concentrator.sv - self-checking bench for bsg_chip_link_concentrator
// Purpose: a queue-based reference model is checked against the DUT on every negedge.
//          Directed scenarios add literal expectations, and a randomized phase follows them.
// Ports: none (top-level bench). Define BSG_LINK_CONC_STATS_EN to also exercise beats_o.
module tb_bsg_chip_link_concentrator;
    localparam int N = 4;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   en_mask_i = '1;
    logic [N-1:0]   v_i = '0;
    logic [N*W-1:0] data_i = '0;
    logic [N-1:0]   last_i = '0;
    logic [N-1:0]   ready_o;
    logic           v_o;
    logic [W-1:0]   data_o;
    logic [1:0]     chan_o;
    logic           last_o;
    logic           ready_i = 1'b0;
`ifdef BSG_LINK_CONC_STATS_EN
    logic [15:0]    beats_o [N];
`endif

    int errors = 0;
    int checks = 0;

    bsg_chip_link_concentrator #(
        .num_in_p(N), .width_p(W), .packet_lock_p(1'b1)
    ) dut (
        .clk_i(clk), .reset_i(rst), .en_mask_i(en_mask_i), .v_i(v_i), .data_i(data_i),
        .last_i(last_i), .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .chan_o(chan_o),
        .last_o(last_o), .ready_i(ready_i)
`ifdef BSG_LINK_CONC_STATS_EN
        , .beats_o(beats_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-channel queues, an rr pointer and a pinned channel.
    // The pinned channel is -1 when free; it is held while stalled or while inside a packet.
    logic [W:0]  q [N][$];
    int          m_rr = 0;
    int          m_commit = -1;
    int unsigned m_beats [N];

    always @(negedge clk) begin
        bit         ev;
        int         ech;
        int         c;
        logic [N-1:0] er;
        logic [W:0] hd;
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                q[k].delete();
                m_beats[k] = 0;
            end
            m_rr = 0;
            m_commit = -1;
            chk("rst_v_o", 64'(v_o), 64'd0);
            chk("rst_ready_o", 64'(ready_o), 64'd0);
            chk("rst_data_o", data_o, 64'd0);
            chk("rst_chan_last", 64'({chan_o, last_o}), 64'd0);
        end else begin
            ev = 1'b0;
            ech = 0;
            if (m_commit >= 0) begin
                ech = m_commit;
                ev = (q[ech].size() != 0);
            end else begin
                for (int i = 0; i < N; i++) begin
                    c = (m_rr + i) % N;
                    if (!ev && q[c].size() != 0 && en_mask_i[c]) begin
                        ev = 1'b1;
                        ech = c;
                    end
                end
            end
            chk("v_o", 64'(v_o), 64'(ev));
            hd = '0;
            if (ev) begin
                hd = q[ech][0];
                chk("data_o", data_o, hd[W-1:0]);
                chk("chan_o", 64'(chan_o), 64'(ech));
                chk("last_o", 64'(last_o), 64'(hd[W]));
            end
            for (int k = 0; k < N; k++) er[k] = (q[k].size() < 2);
            chk("ready_o", 64'(ready_o), 64'(er));
`ifdef BSG_LINK_CONC_STATS_EN
            for (int k = 0; k < N; k++) chk("beats_o", 64'(beats_o[k]), 64'(m_beats[k] % 65536));
`endif
            if (ev && ready_i) begin
                void'(q[ech].pop_front());
                m_beats[ech]++;
                m_rr = (ech + 1) % N;
                m_commit = hd[W] ? -1 : ech;
            end else if (ev) begin
                m_commit = ech;
            end
            for (int k = 0; k < N; k++) begin
                if (v_i[k] && er[k]) q[k].push_back({last_i[k], data_i[k*W +: W]});
            end
        end
    end

    // Inputs change only at posedge+1. The task returns at the following negedge.
    task automatic cyc(input logic [3:0] v, input logic [3:0] l, input logic rdy, input logic [3:0] en);
        @(posedge clk);
        #1;
        v_i = v;
        last_i = l;
        ready_i = rdy;
        en_mask_i = en;
        for (int k = 0; k < N; k++) data_i[k*W +: W] = {$urandom, $urandom};
        @(negedge clk);
    endtask

    logic [W-1:0] d0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        chk("reset_v_o_lit", 64'(v_o), 64'd0);
        chk("reset_ready_lit", 64'(ready_o), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("release_ready", 64'(ready_o), 64'hf);
        chk("release_v_o", 64'(v_o), 64'd0);

        // One single-beat packet on every channel
        cyc(4'hf, 4'hf, 1'b1, 4'hf);
        chk("rr_empty", 64'(v_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(4'h0, 4'hf, 1'b1, 4'hf);
            chk("rr_seq_v", 64'(v_o), 64'd1);
            chk("rr_seq_chan", 64'(chan_o), 64'(i));
        end
        cyc(4'h0, 4'h0, 1'b1, 4'hf);
        chk("rr_done", 64'(v_o), 64'd0);

        // ch1 sends a 3-beat packet with a gap; ch2 waits
        cyc(4'b0110, 4'b0100, 1'b1, 4'hf);
        chk("pkt_c1_v", 64'(v_o), 64'd0);
        cyc(4'b0010, 4'b0000, 1'b1, 4'hf);
        chk("pkt_b1_chan", 64'(chan_o), 64'd1);
        chk("pkt_b1_last", 64'(last_o), 64'd0);
        cyc(4'b0000, 4'b0000, 1'b1, 4'hf);
        chk("pkt_b2_chan", 64'(chan_o), 64'd1);
        cyc(4'b0010, 4'b0010, 1'b1, 4'hf);
        chk("pkt_locked_gap_v", 64'(v_o), 64'd0);
        cyc(4'b0000, 4'b0000, 1'b1, 4'hf);
        chk("pkt_b3_chan", 64'(chan_o), 64'd1);
        chk("pkt_b3_last", 64'(last_o), 64'd1);
        cyc(4'b0000, 4'b0000, 1'b1, 4'hf);
        chk("pkt_then_ch2", 64'(chan_o), 64'd2);
        cyc(4'b0000, 4'b0000, 1'b1, 4'hf);
        chk("pkt_done", 64'(v_o), 64'd0);

        // Stall with rr_ptr=3; ch3 arriving mid-stall must not steal the grant
        cyc(4'b0001, 4'hf, 1'b0, 4'hf);
        cyc(4'b1001, 4'hf, 1'b0, 4'hf);
        chk("stall_chan0", 64'(chan_o), 64'd0);
        d0 = data_o;
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0000, 4'hf, 1'b0, 4'hf);
            chk("stall_v", 64'(v_o), 64'd1);
            chk("stall_chan", 64'(chan_o), 64'd0);
            chk("stall_data", data_o, d0);
            chk("stall_ready", 64'(ready_o), 64'b1110);
        end
        cyc(4'b0000, 4'hf, 1'b1, 4'hf);
        chk("drain_a", 64'(chan_o), 64'd0);
        cyc(4'b0000, 4'hf, 1'b1, 4'hf);
        chk("drain_b", 64'(chan_o), 64'd3);
        cyc(4'b0000, 4'hf, 1'b1, 4'hf);
        chk("drain_c", 64'(chan_o), 64'd0);
        cyc(4'b0000, 4'hf, 1'b1, 4'hf);
        chk("drain_done", 64'(v_o), 64'd0);

        // ch2 disabled; it must never be granted
        for (int i = 0; i < 6; i++) begin
            cyc(4'hf, 4'hf, 1'b1, 4'b1011);
            checks++;
            if (v_o && chan_o == 2'd2) begin
                errors++;
                $display("FAIL mask_ch2_granted: got chan %0d expected not 2", chan_o);
            end
        end
        chk("mask_ch2_full", 64'(ready_o[2]), 64'd0);
        repeat (12) cyc(4'h0, 4'hf, 1'b1, 4'hf);

        // Reset asserted while LOCKED(3)
        cyc(4'b1000, 4'b0000, 1'b1, 4'hf);
        cyc(4'b0000, 4'b0000, 1'b1, 4'hf);
        chk("lk_chan3", 64'(chan_o), 64'd3);
        cyc(4'b1010, 4'b0000, 1'b1, 4'hf);
        chk("lk_gap", 64'(v_o), 64'd0);
        cyc(4'b0000, 4'b0000, 1'b0, 4'hf);
        chk("lk_hold3", 64'(chan_o), 64'd3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("lk_rst_v_o", 64'(v_o), 64'd0);
        chk("lk_rst_ready", 64'(ready_o), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(4'b1010, 4'b1010, 1'b1, 4'hf);
        chk("post_rst_v", 64'(v_o), 64'd0);
        chk("post_rst_ready", 64'(ready_o), 64'hf);
        cyc(4'b0000, 4'b0000, 1'b1, 4'hf);
        chk("post_rst_c1", 64'(chan_o), 64'd1);
        cyc(4'b0000, 4'b0000, 1'b1, 4'hf);
        chk("post_rst_c3", 64'(chan_o), 64'd3);
        cyc(4'b0000, 4'b0000, 1'b1, 4'hf);
        chk("post_rst_done", 64'(v_o), 64'd0);

        // Randomized phase; the model process does all checking here
        repeat (3000) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 299) == 0);
            v_i = 4'($urandom);
            for (int k = 0; k < N; k++) begin
                last_i[k] = ($urandom_range(0, 2) == 0);
                data_i[k*W +: W] = {$urandom, $urandom};
            end
            ready_i = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 63) == 0) en_mask_i = 4'($urandom);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        en_mask_i = 4'hf;
        v_i = '0;

`ifdef BSG_LINK_CONC_STATS_EN
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        v_i = 4'b0001;
        last_i = 4'hf;
        ready_i = 1'b1;
        repeat (70000) @(posedge clk);
        #1 v_i = '0;
        repeat (4) @(negedge clk);
        chk("stats_wrap_ch0", 64'(beats_o[0]), 64'd4464);
        chk("stats_ch1", 64'(beats_o[1]), 64'd0);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
